// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_ctrl_if
//  Brief    : Pipeline-side bundle between the ID/EX/MEM stages and the
//             forwarding + hazard controller. The pipeline is the master and
//             drives the source/producer information; the controller is
//             the slave and returns operand selects and pipe controls.
//  Revision : 1.0  initial release
// ============================================================================
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC*REG_AW-1:0] id_src_i;
  logic [NUM_SRC-1:0]        id_src_vld_i;
  logic                      flush_i;
  logic [REG_AW-1:0]         ex_wreg_i;
  logic                      ex_regw_i;
  logic                      ex_memread_i;
  logic                      ex_mul_i;
  logic [REG_AW-1:0]         mem_wreg_i;
  logic                      mem_regw_i;
  logic [2*NUM_SRC-1:0]      fwd_sel_o;
  logic                      stall_o;
  logic                      bubble_o;
  logic                      ex_hold_o;
  logic                      mul_busy_o;

  modport master (
    output id_src_i, id_src_vld_i, flush_i,
    output ex_wreg_i, ex_regw_i, ex_memread_i, ex_mul_i,
    output mem_wreg_i, mem_regw_i,
    input  fwd_sel_o, stall_o, bubble_o, ex_hold_o, mul_busy_o
  );

  modport slave (
    input  id_src_i, id_src_vld_i, flush_i,
    input  ex_wreg_i, ex_regw_i, ex_memread_i, ex_mul_i,
    input  mem_wreg_i, mem_regw_i,
    output fwd_sel_o, stall_o, bubble_o, ex_hold_o, mul_busy_o
  );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_ctrl
//  Brief    : Forwarding + hazard controller for the 5-stage pipeline.
//             ID sources are compared against the EX and MEM producers one
//             cycle early and the resulting selects are registered into EX.
//             Load-use hazards stall IF/ID and bubble ID/EX; a multi-cycle
//             multiply holds ID/EX and EX for MUL_LAT-1 cycles.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fwd_hazard_ctrl_if.slave  bus
);

  localparam int                CNT_W  = $clog2(MUL_LAT) + 1;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(MUL_LAT - 1);
  localparam logic              MUL_EN = (MUL_LAT > 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*NUM_SRC-1:0] fwd_sel;

  logic [NUM_SRC-1:0]   match_ex;
  logic [NUM_SRC-1:0]   match_mem;
  logic [2*NUM_SRC-1:0] next_sel;

  logic mul_start;
  logic load_use;
  logic wait_hold;

  // Per-source producer compare; register 0 is hard-wired and never forwarded.
  // EX wins over MEM because it holds the younger value. A squashed ID
  // instruction needs no forwarding, so its selects collapse to regfile.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_AW-1:0] src;
    assign src = bus.id_src_i[k*REG_AW +: REG_AW];

    assign match_ex[k]  = bus.id_src_vld_i[k] & bus.ex_regw_i &
                          (bus.ex_wreg_i != '0) & (bus.ex_wreg_i == src);
    assign match_mem[k] = bus.id_src_vld_i[k] & bus.mem_regw_i &
                          (bus.mem_wreg_i != '0) & (bus.mem_wreg_i == src);

    assign next_sel[2*k +: 2] = bus.flush_i  ? 2'b00 :
                                match_ex[k]  ? 2'b01 :
                                match_mem[k] ? 2'b10 : 2'b00;
  end

  // Hazard decode from current state and stage contents; the multiply hold
  // takes priority, so a load-use bubble can never coincide with a hold.
  always_comb begin
    mul_start = (state == RUN) & bus.ex_mul_i & MUL_EN;
    load_use  = (state == RUN) & ~bus.flush_i & bus.ex_memread_i & (|match_ex);
    wait_hold = (state == MUL_WAIT) & (cnt < LAST);
  end

  assign bus.ex_hold_o  = mul_start | wait_hold;
  assign bus.bubble_o   = load_use & ~mul_start;
  assign bus.stall_o    = bus.ex_hold_o | bus.bubble_o;
  assign bus.mul_busy_o = (state == MUL_WAIT);
  assign bus.fwd_sel_o  = fwd_sel;

  // Multiply-hold sequencer and registered EX operand selects.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= RUN;
      cnt     <= '0;
      fwd_sel <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mul_start) begin
            // Selects stay put: the multiply keeps its operands while held.
            cnt   <= CNT_W'(1);
            state <= MUL_WAIT;
          end else if (load_use) begin
            // ID is re-evaluated next cycle once the load sits in MEM.
            fwd_sel <= '0;
          end else begin
            fwd_sel <= next_sel;
          end
        end
        MUL_WAIT: begin
          if (cnt < LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            fwd_sel <= next_sel;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_hazard_ctrl
//  Brief    : Directed bench for fwd_hazard_ctrl. Three instances share one
//             stimulus stream: (NUM_SRC=2, MUL_LAT=4), (3, 2) and (3, 1).
//             Each step queues the expected outputs per instance; the
//             combinational controls are checked mid-cycle and the
//             registered selects after the following rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic [5:0] sel;     // selects expected after this cycle's edge
    logic       stall;
    logic       bubble;
    logic       hold;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [14:0] src;
  logic [2:0]  vld;
  logic        flush, ex_regw, ex_memread, ex_mul, mem_regw;
  logic [4:0]  ex_wreg, mem_wreg;

  int n_chk = 0;
  int n_err = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  fwd_hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2)) if0 ();
  fwd_hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(3)) if1 ();
  fwd_hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(3)) if2 ();

  fwd_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(4)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  fwd_hazard_ctrl #(.REG_AW(5), .NUM_SRC(3), .MUL_LAT(2)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  fwd_hazard_ctrl #(.REG_AW(5), .NUM_SRC(3), .MUL_LAT(1)) dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));

  // Two-source instance sees only the low two source fields.
  assign if0.id_src_i     = src[9:0];
  assign if0.id_src_vld_i = vld[1:0];
  assign if0.flush_i      = flush;
  assign if0.ex_wreg_i    = ex_wreg;
  assign if0.ex_regw_i    = ex_regw;
  assign if0.ex_memread_i = ex_memread;
  assign if0.ex_mul_i     = ex_mul;
  assign if0.mem_wreg_i   = mem_wreg;
  assign if0.mem_regw_i   = mem_regw;

  assign if1.id_src_i     = src;
  assign if1.id_src_vld_i = vld;
  assign if1.flush_i      = flush;
  assign if1.ex_wreg_i    = ex_wreg;
  assign if1.ex_regw_i    = ex_regw;
  assign if1.ex_memread_i = ex_memread;
  assign if1.ex_mul_i     = ex_mul;
  assign if1.mem_wreg_i   = mem_wreg;
  assign if1.mem_regw_i   = mem_regw;

  assign if2.id_src_i     = src;
  assign if2.id_src_vld_i = vld;
  assign if2.flush_i      = flush;
  assign if2.ex_wreg_i    = ex_wreg;
  assign if2.ex_regw_i    = ex_regw;
  assign if2.ex_memread_i = ex_memread;
  assign if2.ex_mul_i     = ex_mul;
  assign if2.mem_wreg_i   = mem_wreg;
  assign if2.mem_regw_i   = mem_regw;

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic exp_t E(input logic [5:0] s, input logic st, input logic bu,
                             input logic h, input logic b);
    exp_t e;
    e.sel = s; e.stall = st; e.bubble = bu; e.hold = h; e.busy = b;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drv(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [2:0] v, input logic fl,
                     input logic [4:0] exw, input logic exr, input logic exm, input logic exmul,
                     input logic [4:0] mw, input logic mr);
    src = {s2, s1, s0}; vld = v; flush = fl;
    ex_wreg = exw; ex_regw = exr; ex_memread = exm; ex_mul = exmul;
    mem_wreg = mw; mem_regw = mr;
  endtask

  task automatic idle();
    drv(5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(input exp_t e0, input exp_t e1, input exp_t e2);
    exp_t x;
    q0.push_back(e0); q1.push_back(e1); q2.push_back(e2);
    #1;
    chk("d0.stall",  6'(if0.stall_o),    6'(q0[0].stall));
    chk("d0.bubble", 6'(if0.bubble_o),   6'(q0[0].bubble));
    chk("d0.hold",   6'(if0.ex_hold_o),  6'(q0[0].hold));
    chk("d0.busy",   6'(if0.mul_busy_o), 6'(q0[0].busy));
    chk("d1.stall",  6'(if1.stall_o),    6'(q1[0].stall));
    chk("d1.bubble", 6'(if1.bubble_o),   6'(q1[0].bubble));
    chk("d1.hold",   6'(if1.ex_hold_o),  6'(q1[0].hold));
    chk("d1.busy",   6'(if1.mul_busy_o), 6'(q1[0].busy));
    chk("d2.stall",  6'(if2.stall_o),    6'(q2[0].stall));
    chk("d2.bubble", 6'(if2.bubble_o),   6'(q2[0].bubble));
    chk("d2.hold",   6'(if2.ex_hold_o),  6'(q2[0].hold));
    chk("d2.busy",   6'(if2.mul_busy_o), 6'(q2[0].busy));
    @(posedge clk);
    #1;
    x = q0.pop_front();
    chk("d0.sel", {2'b00, if0.fwd_sel_o}, {2'b00, x.sel[3:0]});
    x = q1.pop_front();
    chk("d1.sel", if1.fwd_sel_o, x.sel);
    x = q2.pop_front();
    chk("d2.sel", if2.fwd_sel_o, x.sel);
    @(negedge clk);
  endtask

  initial begin
    exp_t z;
    z = '0;
    idle();
    rst = 1'b0;
    @(negedge clk);

    // Reset state while reset is still asserted
    step(z, z, z);
    rst = 1'b1;

    // T1: EX forward, MEM forward, EX beats MEM, 3rd source on EX
    drv(5'd3, 5'd7, 5'd9, 3'b111, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    step(E(6'b000001,0,0,0,0), E(6'b000001,0,0,0,0), E(6'b000001,0,0,0,0));
    drv(5'd3, 5'd7, 5'd9, 3'b111, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
    step(E(6'b000010,0,0,0,0), E(6'b000010,0,0,0,0), E(6'b000010,0,0,0,0));
    drv(5'd3, 5'd7, 5'd9, 3'b111, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1);
    step(E(6'b000001,0,0,0,0), E(6'b000001,0,0,0,0), E(6'b000001,0,0,0,0));
    drv(5'd3, 5'd7, 5'd9, 3'b111, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1);
    step(E(6'b000010,0,0,0,0), E(6'b010010,0,0,0,0), E(6'b010010,0,0,0,0));

    // T2: load-use on rt, then the load sits in MEM and forwards from there
    drv(5'd3, 5'd5, 5'd9, 3'b111, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step(E(6'b000000,1,1,0,0), E(6'b000000,1,1,0,0), E(6'b000000,1,1,0,0));
    drv(5'd3, 5'd5, 5'd9, 3'b111, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
    step(E(6'b001000,0,0,0,0), E(6'b001000,0,0,0,0), E(6'b001000,0,0,0,0));

    // T3: register 0 never matches; an unread source never stalls
    drv(5'd0, 5'd7, 5'd9, 3'b111, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
    step(z, z, z);
    drv(5'd3, 5'd5, 5'd9, 3'b000, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step(z, z, z);

    // Load-use on the third source only: invisible to the two-source unit
    drv(5'd3, 5'd5, 5'd9, 3'b111, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step(z, E(6'b000000,1,1,0,0), E(6'b000000,1,1,0,0));

    // T4: multiply producing $4 with a dependent ID instruction
    drv(5'd4, 5'd7, 5'd9, 3'b111, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
    step(E(6'b000010,0,0,0,0), E(6'b000010,0,0,0,0), E(6'b000010,0,0,0,0));
    drv(5'd4, 5'd7, 5'd9, 3'b111, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
    step(E(6'b000010,1,0,1,0), E(6'b000010,1,0,1,0), E(6'b000001,0,0,0,0));
    step(E(6'b000010,1,0,1,1), E(6'b000001,0,0,0,1), E(6'b000001,0,0,0,0));
    // MUL_LAT=2 instance released and sees the multiply again: restart
    step(E(6'b000010,1,0,1,1), E(6'b000001,1,0,1,0), E(6'b000001,0,0,0,0));
    step(E(6'b000001,0,0,0,1), E(6'b000001,0,0,0,1), E(6'b000001,0,0,0,0));
    drv(5'd4, 5'd7, 5'd9, 3'b111, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
    step(E(6'b000010,0,0,0,0), E(6'b000010,0,0,0,0), E(6'b000010,0,0,0,0));

    // T5: flush masks load-use and zeroes selects
    drv(5'd4, 5'd5, 5'd9, 3'b111, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1);
    step(z, z, z);
    drv(5'd4, 5'd7, 5'd9, 3'b111, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    step(E(6'b000001,0,0,0,0), E(6'b000001,0,0,0,0), E(6'b000001,0,0,0,0));
    // Flush during a multiply hold is ignored by the holding instances
    drv(5'd4, 5'd7, 5'd9, 3'b111, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
    step(E(6'b000001,1,0,1,0), E(6'b000001,1,0,1,0), z);
    flush = 1'b0;
    step(E(6'b000001,1,0,1,1), E(6'b000001,0,0,0,1), E(6'b000001,0,0,0,0));
    flush = 1'b1;
    step(E(6'b000001,1,0,1,1), E(6'b000001,1,0,1,0), z);
    flush = 1'b0;
    step(E(6'b000001,0,0,0,1), E(6'b000001,0,0,0,1), E(6'b000001,0,0,0,0));
    idle();
    step(z, z, z);

    // T6: multiply plus load in EX, then reset mid-MUL_WAIT
    drv(5'd4, 5'd7, 5'd9, 3'b111, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    step(E(6'b000001,0,0,0,0), E(6'b000001,0,0,0,0), E(6'b000001,0,0,0,0));
    drv(5'd4, 5'd7, 5'd9, 3'b111, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
    step(E(6'b000001,1,0,1,0), E(6'b000001,1,0,1,0), E(6'b000000,1,1,0,0));
    idle();
    rst = 1'b0;
    step(E(6'b000000,1,0,1,1), E(6'b000000,0,0,0,1), z);
    rst = 1'b1;
    step(z, z, z);

    // Normal forwarding resumes after reset
    drv(5'd3, 5'd7, 5'd9, 3'b111, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    step(E(6'b000001,0,0,0,0), E(6'b000001,0,0,0,0), E(6'b000001,0,0,0,0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
